led_pattern_engine: RTL and testbench
=====================================

// Module: led_pattern_engine
// PURPOSE
//  Parametrised LED pattern generator driving an N-bit LED bank from the board clock.
//  Internal prescaler produces a step tick; each tick advances one of four patterns.
//  Successor to the single-mode one-hot walking light. Adds run-time mode, speed and pause.
//  Sits between board switch/button inputs and the LED pins.
// PARAMETERS
//  N         16          LED count, >=2
//  BASE_DIV  16777216    clk cycles per step at speed=0, >=2
//  SPD_W     3           speed select width; step period = BASE_DIV*(speed+1) cycles
// PORTS
//  clk        in   1       system clock; all logic on posedge
//  rst        in   1       reset, synchronous, active-low
//  mode       in   2       0=SHL 1=SHR 2=BOUNCE 3=BAR
//  speed      in   SPD_W   step period multiplier minus one
//  pause      in   1       1 = freeze prescaler and pattern
//  step       out  1       1-cycle pulse on each pattern advance
//  led        out  N       LED drive, 1 = on
// BEHAVIOUR
//  Reset (rst=0 at posedge) leaves: cnt=0, pattern=32'h1 truncated to N bits (bit0 only),
//   dir=up, step=0, mode_q=mode sampled, spd_q=speed sampled.
//   With LED_PWM_DIM_EN, pwm_cnt=0.
//  Prescaler: cnt counts 0..LIM-1, LIM=BASE_DIV*(spd_q+1).
//   tick=1 when cnt==LIM-1 and pause=0; cnt then wraps to 0.
//  pause=1: cnt, pattern and dir hold; step=0.
//  spd_q reloads from speed only at tick, so the current period always completes.
//  step is registered: step=1 the same cycle the new pattern appears on led (1 cycle after tick).
//  Mode change (mode!=mode_q) has priority over tick in that cycle:
//   mode_q<=mode, cnt<=0, dir<=up, step<=0.
//   pattern<=seed: SHL/SHR/BOUNCE seed = bit0 one-hot; BAR seed = all zeros.
//  On tick, by mode_q:
//   SHL     one-hot rotate left; bit N-1 -> bit0
//   SHR     one-hot rotate right; bit0 -> bit N-1
//   BOUNCE  one-hot moves toward dir.
//           At bit N-1 with dir=up: dir<=down and move to bit N-2.
//           At bit0 with dir=down: dir<=up and move to bit1.
//           No repeated position at either end; cycle length 2N-2.
//   BAR     pattern <= {pattern[N-2:0],1'b1}; when pattern all ones, next = all zeros.
//           Cycle length N+1.
//  Illegal one-hot (e.g. state upset) in SHL/SHR/BOUNCE: next tick reloads bit0 seed.
//  Reset mid-operation wins over everything; outputs reach reset values next edge.
//  Widths: cnt sized clog2(BASE_DIV*2^SPD_W); the LIM multiply is constant-folded or a small adder chain.
//   No wrap of cnt beyond LIM-1.
// CONFIGURATION
//  LED_PWM_DIM_EN defined:
//   Adds port bright (in, 4) and a 4-bit free-running pwm_cnt.
//   led = pattern & {N{pwm_cnt < bright}}; bright=0 gives all off, bright=15 gives 15/16 duty.
//   Pattern/step timing unchanged.
//  LED_PWM_DIM_EN undefined:
//   No bright port, no pwm_cnt; led = pattern.
// STRUCTURE
//  Package led_pkg: mode_e enum (MODE_SHL, MODE_SHR, MODE_BOUNCE, MODE_BAR), DIR_UP/DIR_DOWN,
//   function onehot_ok(N-bit).
//  Sub-module tick_divider (params BASE_DIV, SPD_W; ports clk, rst, clr, hold, speed, tick):
//   owns cnt and spd_q.
//  Top holds mode_q, pattern, dir, step and the optional PWM.
// TESTING
//  All cases use N=8, BASE_DIV=4.
//  1. Reset, mode=0, speed=0: led=8'h01; step pulses every 4 cycles.
//     led 01->02->...->80->01.
//  2. mode=1, speed=0: led 01->80->40->...->01.
//     Switch speed to 2 mid-period: current period stays 4; following periods are 12 cycles.
//  3. mode=2: led sequence 01,02,04,...,80,40,...,02,01,02; 14 steps per cycle, no repeat at 80 or 01.
//  4. mode=3: led 00,01,03,07,...,FF,00; 9 steps.
//     Change mode to 0 on the same cycle as a tick: no step pulse; led=01; cnt restarts from 0.
//  5. pause=1 for 10 cycles mid-period: led and step frozen; after release the remaining period count resumes.
//     Then rst=0 for 1 cycle: led=01 and step=0 next cycle.
//  6. LED_PWM_DIM_EN build, bright=4: each lit LED is on 4 of every 16 cycles.
//     bright=0: led stays 00.

Source files
------------

// File: rtl/led_pkg.sv
// Shared types and helpers for the LED pattern engine.
// Optional feature macro used by the top: LED_PWM_DIM_EN.
package led_pkg;

    // Widest LED bank the one-hot helper accepts; callers zero-extend.
    localparam int unsigned LED_MAX = 64;

    typedef enum logic [1:0] {
        MODE_SHL    = 2'd0,
        MODE_SHR    = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_BAR    = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // True when exactly one bit is set.
    function automatic logic onehot_ok(input logic [LED_MAX-1:0] v);
        return ($countones(v) == 1);
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Step prescaler: counts 0..BASE_DIV*(spd_q+1)-1 and flags the last count.
// spd_q is only reloaded on a tick so a running period always completes.
module tick_divider
    import led_pkg::*;
#(
    parameter int unsigned BASE_DIV = 16777216,
    parameter int unsigned SPD_W    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             hold,
    input  logic [SPD_W-1:0] speed,
    output logic             tick
);

    localparam int unsigned CW = $clog2(BASE_DIV * (2 ** SPD_W));

    logic [CW-1:0]    cnt;
    logic [SPD_W-1:0] spd_q;
    logic [CW-1:0]    lim_m1;
    logic             at_end;

    // Terminal count for the latched speed setting.
    always_comb begin
        lim_m1 = CW'(BASE_DIV * (int'(spd_q) + 1) - 1);
        at_end = (cnt == lim_m1);
    end

    assign tick = at_end && !hold && !clr;

    // Counter and speed latch; clear beats hold, hold beats counting.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt   <= '0;
            spd_q <= speed;
        end else if (clr) begin
            cnt <= '0;
        end else if (!hold) begin
            if (at_end) begin
                cnt   <= '0;
                spd_q <= speed;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/led_pattern_engine.sv
// LED pattern engine: four run-time selectable patterns stepped by a prescaler.
// Define LED_PWM_DIM_EN to add the 4-bit brightness input and PWM dimming.
module led_pattern_engine
    import led_pkg::*;
#(
    parameter int unsigned N        = 16,
    parameter int unsigned BASE_DIV = 16777216,
    parameter int unsigned SPD_W    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic [SPD_W-1:0] speed,
    input  logic             pause,
`ifdef LED_PWM_DIM_EN
    input  logic [3:0]       bright,
`endif
    output logic             step,
    output logic [N-1:0]     led
);

    mode_e          mode_q;
    dir_e           dir;
    logic [N-1:0]   pattern;
    logic [N-1:0]   next_pattern;
    dir_e           next_dir;
    logic           tick;
    logic           mode_chg;

    assign mode_chg = (mode_e'(mode) != mode_q);

    tick_divider #(
        .BASE_DIV (BASE_DIV),
        .SPD_W    (SPD_W)
    ) u_div (
        .clk   (clk),
        .rst   (rst),
        .clr   (mode_chg),
        .hold  (pause),
        .speed (speed),
        .tick  (tick)
    );

    // Next pattern and bounce direction for the current mode.
    always_comb begin
        next_pattern = pattern;
        next_dir     = dir;
        case (mode_q)
            MODE_SHL: begin
                if (!onehot_ok(LED_MAX'(pattern))) next_pattern = N'(1);
                else next_pattern = {pattern[N-2:0], pattern[N-1]};
            end
            MODE_SHR: begin
                if (!onehot_ok(LED_MAX'(pattern))) next_pattern = N'(1);
                else next_pattern = {pattern[0], pattern[N-1:1]};
            end
            MODE_BOUNCE: begin
                if (!onehot_ok(LED_MAX'(pattern))) begin
                    next_pattern = N'(1);
                    next_dir     = DIR_UP;
                end else if (dir == DIR_UP) begin
                    if (pattern[N-1]) begin
                        next_pattern = pattern >> 1;
                        next_dir     = DIR_DOWN;
                    end else begin
                        next_pattern = pattern << 1;
                    end
                end else begin
                    if (pattern[0]) begin
                        next_pattern = pattern << 1;
                        next_dir     = DIR_UP;
                    end else begin
                        next_pattern = pattern >> 1;
                    end
                end
            end
            default: begin
                if (&pattern) next_pattern = '0;
                else next_pattern = {pattern[N-2:0], 1'b1};
            end
        endcase
    end

    // Pattern state machine; a mode change reseeds and outranks a tick.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mode_q  <= mode_e'(mode);
            pattern <= N'(1);
            dir     <= DIR_UP;
            step    <= 1'b0;
        end else if (mode_chg) begin
            mode_q  <= mode_e'(mode);
            pattern <= (mode_e'(mode) == MODE_BAR) ? '0 : N'(1);
            dir     <= DIR_UP;
            step    <= 1'b0;
        end else if (tick) begin
            pattern <= next_pattern;
            dir     <= next_dir;
            step    <= 1'b1;
        end else begin
            step <= 1'b0;
        end
    end

`ifdef LED_PWM_DIM_EN
    logic [3:0] pwm_cnt;

    // Free-running PWM phase counter.
    always_ff @(posedge clk) begin
        if (!rst) pwm_cnt <= '0;
        else      pwm_cnt <= pwm_cnt + 1'b1;
    end

    assign led = pattern & {N{pwm_cnt < bright}};
`else
    assign led = pattern;
`endif

endmodule

// File: tb/tb_led_pattern_engine.sv
// Directed bench for led_pattern_engine with N=8, BASE_DIV=4, SPD_W=3.
module tb_led_pattern_engine;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] mode;
    logic [2:0] speed;
    logic       pause;
    logic       step;
    logic [7:0] led;
`ifdef LED_PWM_DIM_EN
    logic [3:0] bright;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    led_pattern_engine #(
        .N        (8),
        .BASE_DIV (4),
        .SPD_W    (3)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .mode   (mode),
        .speed  (speed),
        .pause  (pause),
`ifdef LED_PWM_DIM_EN
        .bright (bright),
`endif
        .step   (step),
        .led    (led)
    );

    typedef struct {
        logic [1:0] mode;
        logic [7:0] exp_led;
        int         exp_gap;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick_clk();
        @(posedge clk);
        #1;
    endtask

    // Edges until step is seen high; -1 if none within the bound.
    task automatic wait_step(output int n);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            tick_clk();
            if (step === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    vec_t tbl[$];
    int   gap;
    int   lit;

    initial begin
        // SHL from reset
        tbl.push_back('{2'd0, 8'h02, 4});
        tbl.push_back('{2'd0, 8'h04, 4});
        tbl.push_back('{2'd0, 8'h08, 4});
        tbl.push_back('{2'd0, 8'h10, 4});
        tbl.push_back('{2'd0, 8'h20, 4});
        tbl.push_back('{2'd0, 8'h40, 4});
        tbl.push_back('{2'd0, 8'h80, 4});
        tbl.push_back('{2'd0, 8'h01, 4});
        // SHR: mode change edge adds one cycle to the first gap
        tbl.push_back('{2'd1, 8'h80, 5});
        tbl.push_back('{2'd1, 8'h40, 4});
        tbl.push_back('{2'd1, 8'h20, 4});
        tbl.push_back('{2'd1, 8'h10, 4});
        tbl.push_back('{2'd1, 8'h08, 4});
        tbl.push_back('{2'd1, 8'h04, 4});
        tbl.push_back('{2'd1, 8'h02, 4});
        tbl.push_back('{2'd1, 8'h01, 4});
        // BOUNCE
        tbl.push_back('{2'd2, 8'h02, 5});
        tbl.push_back('{2'd2, 8'h04, 4});
        tbl.push_back('{2'd2, 8'h08, 4});
        tbl.push_back('{2'd2, 8'h10, 4});
        tbl.push_back('{2'd2, 8'h20, 4});
        tbl.push_back('{2'd2, 8'h40, 4});
        tbl.push_back('{2'd2, 8'h80, 4});
        tbl.push_back('{2'd2, 8'h40, 4});
        tbl.push_back('{2'd2, 8'h20, 4});
        tbl.push_back('{2'd2, 8'h10, 4});
        tbl.push_back('{2'd2, 8'h08, 4});
        tbl.push_back('{2'd2, 8'h04, 4});
        tbl.push_back('{2'd2, 8'h02, 4});
        tbl.push_back('{2'd2, 8'h01, 4});
        tbl.push_back('{2'd2, 8'h02, 4});
        // BAR: seed is all zeros
        tbl.push_back('{2'd3, 8'h01, 5});
        tbl.push_back('{2'd3, 8'h03, 4});
        tbl.push_back('{2'd3, 8'h07, 4});
        tbl.push_back('{2'd3, 8'h0F, 4});
        tbl.push_back('{2'd3, 8'h1F, 4});
        tbl.push_back('{2'd3, 8'h3F, 4});
        tbl.push_back('{2'd3, 8'h7F, 4});
        tbl.push_back('{2'd3, 8'hFF, 4});
        tbl.push_back('{2'd3, 8'h00, 4});
        tbl.push_back('{2'd3, 8'h01, 4});

        rst = 1'b0;
        mode = 2'd0;
        speed = 3'd0;
        pause = 1'b0;
`ifdef LED_PWM_DIM_EN
        bright = 4'd15;
`endif
        tick_clk();
        tick_clk();
`ifndef LED_PWM_DIM_EN
        chk("reset_led", int'(led), 8'h01);
`endif
        chk("reset_step", int'(step), 0);
        rst = 1'b1;

`ifndef LED_PWM_DIM_EN
        foreach (tbl[i]) begin
            mode = tbl[i].mode;
            wait_step(gap);
            chk($sformatf("vec%0d_gap", i), gap, tbl[i].exp_gap);
            chk($sformatf("vec%0d_led", i), int'(led), int'(tbl[i].exp_led));
        end

        // Mode change lands on the tick edge: no step, reseed, count restarts
        tick_clk();
        tick_clk();
        tick_clk();
        mode = 2'd0;
        tick_clk();
        chk("modechg_step", int'(step), 0);
        chk("modechg_led", int'(led), 8'h01);
        wait_step(gap);
        chk("modechg_gap", gap, 4);
        chk("modechg_next", int'(led), 8'h02);

        // Speed change mid-period: current period finishes at old length
        mode = 2'd1;
        wait_step(gap);
        chk("shr_gap", gap, 5);
        chk("shr_led", int'(led), 8'h80);
        tick_clk();
        tick_clk();
        speed = 3'd2;
        wait_step(gap);
        chk("spd_rem_gap", gap, 2);
        chk("spd_rem_led", int'(led), 8'h40);
        wait_step(gap);
        chk("spd12a_gap", gap, 12);
        chk("spd12a_led", int'(led), 8'h20);
        wait_step(gap);
        chk("spd12b_gap", gap, 12);
        chk("spd12b_led", int'(led), 8'h10);
        speed = 3'd0;
        wait_step(gap);
        chk("spd12c_gap", gap, 12);
        chk("spd12c_led", int'(led), 8'h08);
        wait_step(gap);
        chk("spd4_gap", gap, 4);
        chk("spd4_led", int'(led), 8'h04);

        // Pause mid-period
        tick_clk();
        tick_clk();
        pause = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick_clk();
            chk($sformatf("pause%0d_step", i), int'(step), 0);
            chk($sformatf("pause%0d_led", i), int'(led), 8'h04);
        end
        pause = 1'b0;
        wait_step(gap);
        chk("resume_gap", gap, 2);
        chk("resume_led", int'(led), 8'h02);

        // Reset mid-operation
        tick_clk();
        rst = 1'b0;
        tick_clk();
        chk("midrst_led", int'(led), 8'h01);
        chk("midrst_step", int'(step), 0);
        rst = 1'b1;
        wait_step(gap);
        chk("postrst_gap", gap, 4);
        chk("postrst_led", int'(led), 8'h80);
`else
        // Freeze the pattern at bit0 and measure duty
        pause = 1'b1;
        bright = 4'd4;
        tick_clk();
        lit = 0;
        for (int i = 0; i < 16; i++) begin
            if (led != 8'h00) lit++;
            chk($sformatf("pwm4_bits%0d", i), int'(led & 8'hFE), 0);
            tick_clk();
        end
        chk("pwm4_duty", lit, 4);
        bright = 4'd0;
        lit = 0;
        for (int i = 0; i < 16; i++) begin
            if (led != 8'h00) lit++;
            tick_clk();
        end
        chk("pwm0_duty", lit, 0);
        pause = 1'b0;
        bright = 4'd15;
        wait_step(gap);
        chk("pwm_step_gap", gap, 4);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
